// File: rtl/psum_su_adder_drain.sv
// Spatial-unrolling psum adder and drain controller: reduces NUM_PE psum lanes per RF entry and streams them to the GB.
// Build option: define SU_ADDER_SAT_EN for a saturating reduction; without it the wide sum wraps.
module psum_su_adder_drain #(
  parameter int DATA_BITWIDTH    = 16,
  parameter int ADDR_BITWIDTH    = 2,
  parameter int DEPTH            = 4,
  parameter int NUM_PE           = 4,
  parameter int GB_ADDR_BITWIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [GB_ADDR_BITWIDTH-1:0]     gb_base_addr,
  input  logic [NUM_PE*DATA_BITWIDTH-1:0] psum_in,
  output logic [ADDR_BITWIDTH-1:0]        addr_from_su_adder,
  output logic                            gb_valid,
  input  logic                            gb_ready,
  output logic [DATA_BITWIDTH-1:0]        gb_data,
  output logic [GB_ADDR_BITWIDTH-1:0]     gb_addr,
  output logic                            busy,
  output logic                            done
);

  localparam int SUM_W = DATA_BITWIDTH + $clog2(NUM_PE);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]      rd_idx_q, rd_idx_d;
  logic [GB_ADDR_BITWIDTH-1:0]   base_q, base_d;
  logic                          gb_valid_q, gb_valid_d;
  logic [DATA_BITWIDTH-1:0]      gb_data_q, gb_data_d;
  logic [GB_ADDR_BITWIDTH-1:0]   gb_addr_q, gb_addr_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          accept;

  // Sign-extend every lane into a guard-bit-wide accumulator, then narrow to the GB data width.
  function automatic logic [DATA_BITWIDTH-1:0] reduce_psum(
    input logic [NUM_PE*DATA_BITWIDTH-1:0] lanes
  );
    logic signed [SUM_W-1:0] sum;
`ifdef SU_ADDER_SAT_EN
    logic signed [SUM_W-1:0] sat_max;
    logic signed [SUM_W-1:0] sat_min;
`endif
    sum = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      sum = sum + SUM_W'($signed(lanes[p*DATA_BITWIDTH +: DATA_BITWIDTH]));
    end
`ifdef SU_ADDER_SAT_EN
    sat_max = {{(SUM_W-DATA_BITWIDTH+1){1'b0}}, {(DATA_BITWIDTH-1){1'b1}}};
    sat_min = {{(SUM_W-DATA_BITWIDTH+1){1'b1}}, {(DATA_BITWIDTH-1){1'b0}}};
    if (sum > sat_max) begin
      reduce_psum = sat_max[DATA_BITWIDTH-1:0];
    end else if (sum < sat_min) begin
      reduce_psum = sat_min[DATA_BITWIDTH-1:0];
    end else begin
      reduce_psum = sum[DATA_BITWIDTH-1:0];
    end
`else
    reduce_psum = sum[DATA_BITWIDTH-1:0];
`endif
  endfunction

  assign accept = !gb_valid_q || gb_ready;

  // Next-state, capture and RF read-address logic.
  always_comb begin
    state_d            = state_q;
    rd_idx_d           = rd_idx_q;
    base_d             = base_q;
    gb_valid_d         = gb_valid_q;
    gb_data_d          = gb_data_q;
    gb_addr_d          = gb_addr_q;
    busy_d             = busy_q;
    done_d             = 1'b0;
    addr_from_su_adder = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = gb_base_addr;
          rd_idx_d = '0;
          busy_d   = 1'b1;
          state_d  = PRIME;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: begin
        state_d = STREAM;
      end
      STREAM: begin
        // A stall keeps the address on the pending entry so the RF re-presents it.
        if (accept) begin
          gb_data_d          = reduce_psum(psum_in);
          gb_addr_d          = base_q + GB_ADDR_BITWIDTH'(rd_idx_q);
          gb_valid_d         = 1'b1;
          rd_idx_d           = rd_idx_q + ADDR_BITWIDTH'(1);
          addr_from_su_adder = rd_idx_q + ADDR_BITWIDTH'(1);
          if (rd_idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else begin
          addr_from_su_adder = rd_idx_q;
        end
      end
      DRAIN: begin
        if (gb_valid_q && gb_ready) begin
          gb_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      base_q     <= '0;
      gb_valid_q <= 1'b0;
      gb_data_q  <= '0;
      gb_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      base_q     <= base_d;
      gb_valid_q <= gb_valid_d;
      gb_data_q  <= gb_data_d;
      gb_addr_q  <= gb_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign gb_valid = gb_valid_q;
  assign gb_data  = gb_data_q;
  assign gb_addr  = gb_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/psum_su_adder_drain.md
# psum_su_adder_drain

Spatial-unrolling (SU) adder and drain controller that sits directly downstream of the per-PE double-buffered psum register files. After the control logic swaps buffers, this block walks the idle psum bank of every PE in lockstep. It sums the NUM_PE partial sums for each address and streams the reduced results to the global buffer over a valid/ready interface.

## Interface
- DATA_BITWIDTH, 16: psum width per PE, signed two's complement
- ADDR_BITWIDTH, 2: RF address width
- DEPTH, 4: psum entries per RF bank, 2..2^ADDR_BITWIDTH
- NUM_PE, 4: number of PEs reduced together, ≥2
- GB_ADDR_BITWIDTH, 8: global-buffer address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse: drain the idle bank; ignored unless IDLE
- gb_base_addr  in  GB_ADDR_BITWIDTH  GB address of entry 0; sampled on accepted start
- psum_in  in  NUM_PE*DATA_BITWIDTH  registered out1/out2 of the idle bank, PE p at bits [p*DATA_BITWIDTH +: DATA_BITWIDTH]
- addr_from_su_adder  out  ADDR_BITWIDTH  read address broadcast to all PE RFs (combinational)
- gb_valid  out  1  gb_data/gb_addr valid
- gb_ready  in  1  GB accepts when gb_valid && gb_ready at a rising edge
- gb_data  out  DATA_BITWIDTH  reduced psum
- gb_addr  out  GB_ADDR_BITWIDTH  gb_base_addr + entry index (mod 2^GB_ADDR_BITWIDTH)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last handshake

## Operation
- FSM states: IDLE, PRIME, STREAM, DRAIN.
- IDLE: on start, latch base, clear rd_idx to 0, set busy=1, and go to PRIME.
- PRIME: addr=0. The RF registers entry 0 at this edge. Go to STREAM.
- STREAM: psum_in holds mem[rd_idx] for every PE.
  - accept = !gb_valid || gb_ready.
  - On accept: gb_data <= reduce(psum_in), gb_addr <= base+rd_idx, gb_valid <= 1, rd_idx <= rd_idx+1.
  - addr_from_su_adder = accept ? rd_idx+1 : rd_idx. A stall re-reads the same entry, so no data is lost.
  - When rd_idx==DEPTH-1 and accept, go to DRAIN. The address driven on that edge wraps to 0 and is don't-care.
- DRAIN: hold gb_valid until the handshake. On handshake: gb_valid <= 0, done <= 1, busy <= 0, state <= IDLE.
- gb_valid drops at any handshake edge where no new capture occurs.
- In IDLE and DRAIN, addr_from_su_adder = 0.
- Reduction:
  - Sign-extend each lane to DATA_BITWIDTH+clog2(NUM_PE) bits and add all lanes.
  - Convert the result to DATA_BITWIDTH as defined under Configuration.
- The upstream control must keep en1 stable, with the drained bank idle, from start until done.
- A start received while not in IDLE is ignored and has no side effects.
- Reset at any time forces IDLE. The drain in progress is abandoned and no done pulse is issued.

## Timing
- Reset values: addr_from_su_adder=0, gb_valid=0, gb_data=0, gb_addr=0, busy=0, done=0, state IDLE, rd_idx=0.
- Start sampled at edge E0. PRIME is the cycle after E0. First capture at E0+2, so gb_valid is high from E0+2.
- With gb_ready held at 1: one result per cycle, entries at edges E0+2..E0+DEPTH+1, done pulse after edge E0+DEPTH+2.
- Each gb_ready=0 cycle while gb_valid is high adds exactly one cycle. gb_data and gb_addr hold stable while stalled.
- Combinational paths gb_ready→addr_from_su_adder and state→addr_from_su_adder exist. There is no path from psum_in to any output.
- done and the busy fall occur on the same edge. start is accepted in the following cycle.

## Configuration
- SU_ADDER_SAT_EN defined: the wide sum saturates to [−2^(DATA_BITWIDTH−1), 2^(DATA_BITWIDTH−1)−1].
- SU_ADDER_SAT_EN undefined: the wide sum is truncated to its low DATA_BITWIDTH bits (two's-complement wrap).

## Test plan
- Basic drain, defaults, gb_ready=1, base=0x10, PE p entry k = (p+1)*(k+1) → gb_data 10,20,30,40 at gb_addr 0x10..0x13. gb_valid spans 4 cycles starting 2 cycles after start. done is 1 cycle after the last handshake.
- Backpressure: drop gb_ready at the 2nd and 3rd results for 3 cycles each → data and address held, order preserved. addr_from_su_adder repeats the pending index. Total time is 6 cycles longer than the basic drain.
- Overflow: all 4 lanes 0x7000 → wrap build 0xC000, SU_ADDER_SAT_EN build 0x7FFF. All lanes 0x8000 → wrap 0x0000, sat 0x8000. Mixed lanes {0x7FFF,1,−1,−0x7FFF} → 0x0000 in both builds.
- Start while busy: pulse start at result 2 with a different base → ignored, addresses continue from the original base.
- Reset mid-drain: assert reset after the 2nd handshake → all outputs 0 immediately, no done pulse. A new start then drains all 4 entries from index 0.
- Wrap of GB address: base=0xFE → gb_addr 0xFE, 0xFF, 0x00, 0x01.
